// File: rtl/xy_route_ejector.sv
// 5-port XY mesh router stage: one hold register per input, column-first routing, per-output round-robin into registered outputs.
// Optional per-output delivered-flit counters when XY_EJECT_STATS_EN is defined.
module xy_route_ejector #(
    parameter int COORD_W = 3,
    parameter int DATA_W  = 10,
    parameter int MY_X    = 4,
    parameter int MY_Y    = 4,
    parameter int CNT_W   = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [5*DATA_W-1:0] in_data,
    input  logic [4:0]          in_valid,
    output logic [4:0]          in_ready,
    output logic [5*DATA_W-1:0] out_data,
    output logic [4:0]          out_valid,
    input  logic [4:0]          out_ready
`ifdef XY_EJECT_STATS_EN
    ,
    output logic [5*CNT_W-1:0]  flit_cnt
`endif
);

    localparam logic [COORD_W-1:0] MY_X_C = COORD_W'(MY_X);
    localparam logic [COORD_W-1:0] MY_Y_C = COORD_W'(MY_Y);

    logic [4:0]        hold_v_q, hold_v_d;
    logic [DATA_W-1:0] hold_dat_q [5];
    logic [DATA_W-1:0] hold_dat_d [5];
    logic [4:0]        out_v_q, out_v_d;
    logic [DATA_W-1:0] out_dat_q [5];
    logic [DATA_W-1:0] out_dat_d [5];
    logic [2:0]        ptr_q [5];
    logic [2:0]        ptr_d [5];

    logic [2:0]        route [5];
    logic [4:0]        gnt_v;
    logic [2:0]        gnt_idx [5];
    logic [4:0]        grant_taken;

    function automatic logic [2:0] xy_route(input logic [DATA_W-1:0] flit);
        logic [COORD_W-1:0] col;
        logic [COORD_W-1:0] row;
        col = flit[COORD_W-1:0];
        row = flit[2*COORD_W-1:COORD_W];
        if (col > MY_X_C)      return 3'd0;
        else if (col < MY_X_C) return 3'd1;
        else if (row > MY_Y_C) return 3'd2;
        else if (row < MY_Y_C) return 3'd3;
        else                   return 3'd4;
    endfunction

    // Round-robin search starts one past the last winner of each output.
    always_comb begin
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 5; i++) begin
            route[i] = xy_route(hold_dat_q[i]);
        end
        for (int o = 0; o < 5; o++) begin
            gnt_v[o]   = 1'b0;
            gnt_idx[o] = 3'd0;
            if (!out_v_q[o] || out_ready[o]) begin
                for (int k = 1; k <= 5; k++) begin
                    idx = 3'((int'(ptr_q[o]) + k) % 5);
                    if (!gnt_v[o] && hold_v_q[idx] && route[idx] == 3'(o)) begin
                        gnt_v[o]   = 1'b1;
                        gnt_idx[o] = idx;
                    end
                end
            end
        end
        grant_taken = 5'd0;
        for (int o = 0; o < 5; o++) begin
            for (int i = 0; i < 5; i++) begin
                if (gnt_v[o] && gnt_idx[o] == 3'(i)) begin
                    grant_taken[i] = 1'b1;
                end
            end
        end
    end

    // A held flit leaving this cycle frees its slot for a same-cycle refill.
    assign in_ready = ~hold_v_q | grant_taken;

    always_comb begin
        hold_v_d = hold_v_q;
        out_v_d  = out_v_q;
        for (int i = 0; i < 5; i++) begin
            hold_dat_d[i] = hold_dat_q[i];
            if (in_valid[i] && in_ready[i]) begin
                hold_v_d[i]   = 1'b1;
                hold_dat_d[i] = in_data[i*DATA_W +: DATA_W];
            end else if (grant_taken[i]) begin
                hold_v_d[i] = 1'b0;
            end
        end
        for (int o = 0; o < 5; o++) begin
            out_dat_d[o] = out_dat_q[o];
            ptr_d[o]     = ptr_q[o];
            if (gnt_v[o]) begin
                out_v_d[o] = 1'b1;
                ptr_d[o]   = gnt_idx[o];
                for (int i = 0; i < 5; i++) begin
                    if (gnt_idx[o] == 3'(i)) begin
                        out_dat_d[o] = hold_dat_q[i];
                    end
                end
            end else if (out_ready[o]) begin
                out_v_d[o] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_v_q <= 5'd0;
            out_v_q  <= 5'd0;
            for (int i = 0; i < 5; i++) begin
                hold_dat_q[i] <= '0;
                out_dat_q[i]  <= '0;
                ptr_q[i]      <= 3'd4;
            end
        end else begin
            hold_v_q <= hold_v_d;
            out_v_q  <= out_v_d;
            for (int i = 0; i < 5; i++) begin
                hold_dat_q[i] <= hold_dat_d[i];
                out_dat_q[i]  <= out_dat_d[i];
                ptr_q[i]      <= ptr_d[i];
            end
        end
    end

    always_comb begin
        out_valid = out_v_q;
        out_data  = '0;
        for (int o = 0; o < 5; o++) begin
            out_data[o*DATA_W +: DATA_W] = out_dat_q[o];
        end
    end

`ifdef XY_EJECT_STATS_EN
    logic [CNT_W-1:0] cnt_q [5];
    logic [CNT_W-1:0] cnt_d [5];

    // Counters saturate rather than wrap.
    always_comb begin
        flit_cnt = '0;
        for (int o = 0; o < 5; o++) begin
            cnt_d[o] = cnt_q[o];
            if (out_v_q[o] && out_ready[o] && cnt_q[o] != '1) begin
                cnt_d[o] = cnt_q[o] + 1'b1;
            end
            flit_cnt[o*CNT_W +: CNT_W] = cnt_q[o];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int o = 0; o < 5; o++) cnt_q[o] <= '0;
        end else begin
            for (int o = 0; o < 5; o++) cnt_q[o] <= cnt_d[o];
        end
    end
`endif

endmodule

// File: tb/tb_xy_route_ejector.sv
// Directed bench for xy_route_ejector at COORD_W=3, DATA_W=10, router at (4,4).
module tb_xy_route_ejector;

    logic        clk = 1'b0;
    logic        rst;
    logic [49:0] in_data;
    logic [4:0]  in_valid;
    logic [4:0]  in_ready;
    logic [49:0] out_data;
    logic [4:0]  out_valid;
    logic [4:0]  out_ready;
`ifdef XY_EJECT_STATS_EN
    logic [19:0] flit_cnt;
`endif

    int total = 0;
    int bad   = 0;

    xy_route_ejector #(
        .COORD_W(3), .DATA_W(10), .MY_X(4), .MY_Y(4), .CNT_W(4)
    ) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
`ifdef XY_EJECT_STATS_EN
        , .flit_cnt(flit_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int         port;
        logic [9:0] dat;
        int         exp_o;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [9:0] oslice(input int o);
        return out_data[o*10 +: 10];
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 5'd0;
        out_ready = 5'h1F;
        step();
        rst = 1'b0;
    endtask

    initial begin
        logic [3:0] tags [5];
        int seq_in, seq_out, first, last;
        logic acc, seen;

        vecs[0] = '{4, {4'h1, 6'b100_110}, 0};
        vecs[1] = '{4, {4'h2, 6'b100_100}, 4};
        vecs[2] = '{4, {4'h3, 6'b110_100}, 2};
        vecs[3] = '{4, {4'h4, 6'b010_100}, 3};
        vecs[4] = '{4, {4'h5, 6'b001_011}, 1};
        vecs[5] = '{0, {4'h6, 6'b000_111}, 0};
        vecs[6] = '{1, {4'h7, 6'b111_000}, 1};
        vecs[7] = '{2, {4'h8, 6'b111_100}, 2};
        vecs[8] = '{3, {4'h9, 6'b000_100}, 3};
        vecs[9] = '{2, {4'hA, 6'b101_101}, 0};

        // Reset with every input offering a flit.
        rst = 1'b1;
        in_valid = 5'h1F;
        in_data = {5{10'h2A4}};
        out_ready = 5'd0;
        step();
        step();
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_out_data", 32'(out_data[31:0]), 32'h0);
`ifdef XY_EJECT_STATS_EN
        chk("rst_flit_cnt", 32'(flit_cnt), 32'h0);
`endif
        rst = 1'b0;
        in_valid = 5'd0;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'h1F);

        // Single-flit routing vectors.
        out_ready = 5'h1F;
        for (int v = 0; v < 10; v++) begin
            in_valid = 5'd0;
            in_valid[vecs[v].port] = 1'b1;
            in_data[vecs[v].port*10 +: 10] = vecs[v].dat;
            #1;
            chk($sformatf("v%0d_in_ready", v), 32'(in_ready[vecs[v].port]), 32'h1);
            step();
            in_valid = 5'd0;
            chk($sformatf("v%0d_lat", v), 32'(out_valid), 32'h0);
            step();
            chk($sformatf("v%0d_valid", v), 32'(out_valid), 32'(5'd1 << vecs[v].exp_o));
            chk($sformatf("v%0d_data", v), 32'(oslice(vecs[v].exp_o)), 32'(vecs[v].dat));
            step();
            chk($sformatf("v%0d_drain", v), 32'(out_valid), 32'h0);
        end

        // Round-robin on LOCAL: ports 0..3 together, then 0..4 together.
        do_reset();
        for (int p = 0; p < 4; p++) in_data[p*10 +: 10] = {4'(p + 1), 6'b100_100};
        in_valid = 5'b01111;
        step();
        in_valid = 5'd0;
        step();
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("rr1_valid%0d", k), 32'(out_valid), 32'h10);
            chk($sformatf("rr1_src%0d", k), 32'(oslice(4)), 32'({4'(k + 1), 6'b100_100}));
            step();
        end
        for (int p = 0; p < 5; p++) in_data[p*10 +: 10] = {4'(p + 8), 6'b100_100};
        in_valid = 5'h1F;
        step();
        in_valid = 5'd0;
        step();
        tags = '{4'd12, 4'd8, 4'd9, 4'd10, 4'd11};
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("rr2_src%0d", k), 32'(oslice(4)), 32'({tags[k], 6'b100_100}));
            step();
        end
        chk("rr2_drain", 32'(out_valid), 32'h0);

        // EAST back-pressure for 5 cycles, then release.
        do_reset();
        out_ready = 5'b11110;
        seq_in = 0; seq_out = 0; first = -1; last = -1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            in_valid = (seq_in < 8) ? 5'b10000 : 5'd0;
            in_data[40 +: 10] = {4'(seq_in), 6'b100_110};
            #1;
            if (cyc == 5) begin
                chk("bp_out_valid", 32'(out_valid[0]), 32'h1);
                chk("bp_out_tag", 32'(out_data[9:6]), 32'h0);
                chk("bp_in_ready", 32'(in_ready[4]), 32'h0);
                chk("bp_accepted", 32'(seq_in), 32'd2);
            end
            if (cyc >= 5) out_ready[0] = 1'b1;
            #1;
            acc = in_valid[4] && in_ready[4];
            if (out_valid[0] && out_ready[0]) begin
                chk($sformatf("bp_seq%0d", seq_out), 32'(out_data[9:6]), 32'(seq_out));
                if (first < 0) first = cyc;
                last = cyc;
                seq_out++;
            end
            step();
            if (acc) seq_in++;
        end
        chk("bp_count", 32'(seq_out), 32'd8);
        chk("bp_rate", 32'(last - first), 32'd7);

        // Reset discards flits held in three ports.
        do_reset();
        out_ready = 5'd0;
        for (int p = 0; p < 3; p++) in_data[p*10 +: 10] = {4'(p + 1), 6'b100_111};
        in_valid = 5'b00111;
        step();
        in_valid = 5'd0;
        step();
        chk("mid_pre_valid", 32'(out_valid), 32'h1);
        rst = 1'b1;
        step();
        chk("mid_rst_valid", 32'(out_valid), 32'h0);
        chk("mid_rst_ready", 32'(in_ready), 32'h1F);
        rst = 1'b0;
        out_ready = 5'h1F;
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step();
            if (out_valid != 5'd0) seen = 1'b1;
        end
        chk("mid_no_emerge", 32'(seen), 32'h0);

`ifdef XY_EJECT_STATS_EN
        // 20 flits to NORTH saturate the 4-bit counter.
        do_reset();
        in_data[40 +: 10] = {4'h3, 6'b110_100};
        in_valid = 5'b10000;
        for (int k = 0; k < 20; k++) step();
        in_valid = 5'd0;
        for (int k = 0; k < 4; k++) step();
        chk("cnt_north_sat", 32'(flit_cnt[8 +: 4]), 32'hF);
        chk("cnt_east_zero", 32'(flit_cnt[0 +: 4]), 32'h0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
